sumador_serie_n_bits: RTL and testbench

- Parametrised bit-serial adder/subtractor for the ALU group.
- Adds or subtracts two N-bit operands one bit per clock, using a single full-adder slice and a registered carry, LSB first.
- start/busy/done handshake; result, carry-out and signed-overflow flags are held until the next operation.
- Successor of the 1-bit full adder: generalised in width, with add/sub mode and multi-cycle sequencing.

---
 rtl/sumador_serie_n_bits.sv | 124 ++++++++++++
 tb/tb_sumador_serie_n_bits.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sumador_serie_n_bits.sv
// Bit-serial N-bit adder/subtractor: one full-adder slice, registered carry, LSB first.
// start/busy/done handshake; result and flags hold until the next operation finishes.
module sumador_serie_n_bits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         resta,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  s_q, s_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_out_q, c_out_d;
    logic          ovf_q, ovf_d;

    logic          sum_bit;
    logic          carry_nxt;
    logic [N-1:0]  s_shift;

    // The single full-adder slice shared by every bit position.
    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // New sum bits enter at the MSB so the result ends up LSB-aligned after N shifts.
    generate
        if (N == 1) begin : g_s_one
            assign s_shift = sum_bit;
        end else begin : g_s_many
            assign s_shift = {sum_bit, s_q[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    // Subtraction is x + ~y + ~borrow, so c_out reads as NOT borrow.
                    a_d     = x;
                    b_d     = resta ? ~y : y;
                    carry_d = resta ? ~c_in : c_in;
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = SUMA;
                end else begin
                    state_d = IDLE;
                end
            end
            SUMA: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_nxt;
                s_d     = s_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // On the MSB step carry_q is the carry into the MSB.
                    c_out_d = carry_nxt;
                    ovf_d   = carry_q ^ carry_nxt;
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q == SUMA);
    assign done  = (state_q == FIN);

endmodule

// File: tb/tb_sumador_serie_n_bits.sv
// Directed bench for the bit-serial adder: N=4 hand-computed vectors plus an N=3 sweep
// against a signed/unsigned arithmetic reference.
module tb_sumador_serie_n_bits;

    logic       clk;
    logic       rst;

    logic       start4, resta4, cin4;
    logic [3:0] x4, y4;
    logic [3:0] s4;
    logic       cout4, ovf4, busy4, done4;

    logic       start3, resta3, cin3;
    logic [2:0] x3, y3;
    logic [2:0] s3;
    logic       cout3, ovf3, busy3, done3;

    int tests;
    int fails;

    sumador_serie_n_bits #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .resta(resta4),
        .x(x4), .y(y4), .c_in(cin4),
        .s(s4), .c_out(cout4), .ovf(ovf4), .busy(busy4), .done(done4)
    );

    sumador_serie_n_bits #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .resta(resta3),
        .x(x3), .y(y3), .c_in(cin3),
        .s(s3), .c_out(cout3), .ovf(ovf3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One N=4 operation with full latency/handshake checking.
    task automatic op4(input string tag, input logic [3:0] xa, input logic [3:0] yb,
                       input logic ci, input logic rs,
                       input logic [3:0] es, input logic ec, input logic eo);
        x4 = xa; y4 = yb; cin4 = ci; resta4 = rs; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk({tag, "_acc_bd"}, 8'({busy4, done4}), 8'b10);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk({tag, "_run_bd"}, 8'({busy4, done4}), 8'b10);
        end
        tick();
        chk({tag, "_fin_bd"}, 8'({busy4, done4}), 8'b01);
        chk({tag, "_s"}, 8'(s4), 8'(es));
        chk({tag, "_cout"}, 8'(cout4), 8'(ec));
        chk({tag, "_ovf"}, 8'(ovf4), 8'(eo));
        tick();
        chk({tag, "_idle_bd"}, 8'({busy4, done4}), 8'b00);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        start4 = 0; resta4 = 0; cin4 = 0; x4 = 0; y4 = 0;
        start3 = 0; resta3 = 0; cin3 = 0; x3 = 0; y3 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s", 8'(s4), 8'h0);
        chk("rst_flags", 8'({cout4, ovf4, busy4, done4}), 8'h0);
        rst = 1'b0;
        tick();
        chk("idle_bd", 8'({busy4, done4}), 8'b00);

        // Addition vectors.
        op4("add_3_5",    4'd3,  4'd5, 1'b0, 1'b0, 4'd8,  1'b0, 1'b1);
        op4("add_15_1",   4'd15, 4'd1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0);
        op4("add_7_7_c1", 4'd7,  4'd7, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1);

        // start held high, operands scrambled during SUMA: expect 1+1=2 then 2+3=5.
        resta4 = 0; cin4 = 0; x4 = 4'd1; y4 = 4'd1; start4 = 1'b1;
        tick();
        chk("hold_acc_bd", 8'({busy4, done4}), 8'b10);
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) begin
                x4 = 4'd2; y4 = 4'd3;
            end else begin
                x4 = 4'(i * 5 + 3); y4 = 4'(i * 7 + 1);
            end
            tick();
            if (i == 4 || i == 9) begin
                chk("hold_done_bd", 8'({busy4, done4}), 8'b01);
                chk("hold_s", 8'(s4), (i == 4) ? 8'd2 : 8'd5);
            end else begin
                chk("hold_busy_bd", 8'({busy4, done4}), 8'b10);
            end
        end
        start4 = 1'b0;
        while (busy4) tick();
        tick();
        chk("hold_end_bd", 8'({busy4, done4}), 8'b00);

        // Subtraction vectors.
        op4("sub_5_3", 4'd5, 4'd3, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0);
        op4("sub_3_5", 4'd3, 4'd5, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
        op4("sub_8_1", 4'd8, 4'd1, 1'b0, 1'b1, 4'd7,  1'b1, 1'b1);

        // Reset two cycles into SUMA; previous flags (c_out=1, ovf=1) must hold until then.
        x4 = 4'd9; y4 = 4'd6; cin4 = 0; resta4 = 0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        chk("mid_flags_held", 8'({cout4, ovf4}), 8'b11);
        tick();
        chk("mid_busy", 8'(busy4), 8'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_s", 8'(s4), 8'h0);
        chk("mid_rst_flags", 8'({cout4, ovf4, busy4, done4}), 8'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 8'({busy4, done4}), 8'b00);
        op4("after_rst_1_2", 4'd1, 4'd2, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);

        // Exhaustive N=3 sweep.
        for (int rs = 0; rs < 2; rs++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int xa = 0; xa < 8; xa++) begin
                    for (int yb = 0; yb < 8; yb++) begin
                        int sx, sy, sres, ures;
                        logic es_c, es_o;
                        logic [2:0] es_s;
                        sx = (xa >= 4) ? xa - 8 : xa;
                        sy = (yb >= 4) ? yb - 8 : yb;
                        if (rs == 1) begin
                            ures = xa - yb - ci;
                            sres = sx - sy - ci;
                            es_c = (xa >= yb + ci);
                        end else begin
                            ures = xa + yb + ci;
                            sres = sx + sy + ci;
                            es_c = (ures > 7);
                        end
                        es_s = 3'(ures);
                        es_o = (sres > 3) || (sres < -4);
                        x3 = 3'(xa); y3 = 3'(yb); cin3 = ci[0]; resta3 = rs[0];
                        start3 = 1'b1;
                        tick();
                        start3 = 1'b0;
                        repeat (3) tick();
                        chk("sw3_done", 8'({busy3, done3}), 8'b01);
                        chk("sw3_s", 8'(s3), 8'(es_s));
                        chk("sw3_flags", 8'({cout3, ovf3}), 8'({es_c, es_o}));
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
